// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared constants, FSM states and decompression for the ciphertext unpacker
package kyber_pkg;
  localparam int Q  = 3329;
  localparam int N  = 256;
  localparam int K  = 2;
  localparam int DU = 10;
  localparam int DV = 4;
  localparam int CW = K * N * DU + N * DV;

  localparam logic [1:0] POLY_LAST_U = 2'(K - 1);
  localparam logic [7:0] COEF_LAST   = 8'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN_U, RUN_V} state_t;

  // y = round(x * Q / 2^d); the DU+12 bit product covers the widest (u) case
  function automatic logic [11:0] decompress(input logic [DU-1:0] x, input int d);
    logic [DU+11:0] p;
    logic [DU+11:0] s;
    p = {{12{1'b0}}, x} * (DU + 12)'(Q) + ((DU + 12)'(1) << (d - 1));
    s = p >> d;
    return s[11:0];
  endfunction
endpackage

// File: rtl/kyber_decompress.sv
// rtl/kyber_decompress.sv - combinational decompression of one D-bit coefficient
module kyber_decompress
  import kyber_pkg::*;
#(
  parameter int D = DU
) (
  input  logic [D-1:0] x,
  output logic [11:0]  y
);
  assign y = decompress(DU'(x), D);
endmodule

// File: rtl/kyber_ct_unpack.sv
// rtl/kyber_ct_unpack.sv - loads one packed ciphertext and streams its 768 decompressed coefficients
module kyber_ct_unpack
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] c_in,
  output logic [11:0]   coef_out,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [1:0]    poly_idx,
  output logic [7:0]    coef_idx,
  output logic          coef_last,
  output logic          busy,
  output logic          done
);
  state_t        state, state_next;
  logic [CW-1:0] sh;
  logic [1:0]    poly;
  logic [7:0]    coef;
  logic          done_q;
  logic [11:0]   y_u, y_v;
  logic          xfer, end_u, end_v;

  kyber_decompress #(.D(DU)) u_dec_u (.x(sh[DU-1:0]), .y(y_u));
  kyber_decompress #(.D(DV)) u_dec_v (.x(sh[DV-1:0]), .y(y_v));

  assign xfer  = (state != IDLE) && coef_ready;
  assign end_u = (state == RUN_U) && (poly == POLY_LAST_U) && (coef == COEF_LAST);
  assign end_v = (state == RUN_V) && (coef == COEF_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN_U;
      RUN_U:   if (xfer && end_u) state_next = RUN_V;
      RUN_V:   if (xfer && end_v) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      poly   <= '0;
      coef   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= xfer && end_v;
      case (state)
        IDLE: begin
          if (start) begin
            sh   <= c_in;
            poly <= '0;
            coef <= '0;
          end
        end
        RUN_U: begin
          if (xfer) begin
            sh   <= sh >> DU;
            coef <= coef + 8'd1;
            if (coef == COEF_LAST) poly <= poly + 2'd1;
          end
        end
        RUN_V: begin
          // coef wraps to 0 on the last transfer, leaving idle indices at 0
          if (xfer) begin
            sh   <= sh >> DV;
            coef <= coef + 8'd1;
            if (coef == COEF_LAST) poly <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign coef_valid = (state != IDLE);
  assign busy       = (state != IDLE);
  assign coef_out   = (state == RUN_U) ? y_u : ((state == RUN_V) ? y_v : 12'd0);
  assign poly_idx   = poly;
  assign coef_idx   = coef;
  assign coef_last  = end_v;
  assign done       = done_q;
endmodule

// File: tb/tb_kyber_ct_unpack.sv
// tb/tb_kyber_ct_unpack.sv - directed self-checking bench for kyber_ct_unpack
module tb_kyber_ct_unpack;
  logic          clk = 1'b0;
  logic          rst, start, coef_ready;
  logic [6143:0] c_in;
  logic [11:0]   coef_out;
  logic          coef_valid, coef_last, busy, done;
  logic [1:0]    poly_idx;
  logic [7:0]    coef_idx;

  int total = 0;
  int fails = 0;
  logic [11:0] got[768];
  logic [11:0] ref_s[768];
  int n_got, idx_err, stall_err, last_err, busy_cyc, cycles, errs;
  logic [6143:0] c2, crand;

  kyber_ct_unpack dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in),
    .coef_out(coef_out), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .poly_idx(poly_idx), .coef_idx(coef_idx), .coef_last(coef_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sw_dec(input int x, input int d);
    int r;
    r = (x * 3329 + (1 << (d - 1))) >> d;
    return 12'(r);
  endfunction

  task automatic collect(input bit rnd, input int pulse_at);
    logic [11:0] p_out;
    logic [1:0]  p_poly;
    logic [7:0]  p_cidx;
    logic        p_last;
    bit          p_stall;
    bit          pulsed;
    p_stall = 0; pulsed = 0;
    p_out = '0; p_poly = '0; p_cidx = '0; p_last = 1'b0;
    n_got = 0; idx_err = 0; stall_err = 0; last_err = 0; busy_cyc = 0; cycles = 0;
    while (n_got < 768 && cycles < 20000) begin
      start = 1'b0;
      if (n_got == pulse_at && !pulsed) begin
        start  = 1'b1;
        c_in   = ~c_in;
        pulsed = 1;
      end
      coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_cyc++;
      if (!coef_valid) stall_err++;
      if (p_stall && (coef_out !== p_out || poly_idx !== p_poly ||
                      coef_idx !== p_cidx || coef_last !== p_last)) stall_err++;
      if (coef_valid && coef_ready) begin
        if (poly_idx !== 2'(n_got / 256) || coef_idx !== 8'(n_got % 256)) idx_err++;
        if (coef_last !== (n_got == 767)) last_err++;
        got[n_got] = coef_out;
        n_got++;
      end
      p_stall = coef_valid && !coef_ready;
      p_out = coef_out; p_poly = poly_idx; p_cidx = coef_idx; p_last = coef_last;
      step();
      cycles++;
    end
    start = 1'b0;
    check("stream_len", n_got, 768);
    check("idx_seq_errors", idx_err, 0);
    check("hold_valid_errors", stall_err, 0);
    check("last_flag_errors", last_err, 0);
    check("done_after_last", done, 1);
    check("busy_after_last", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; coef_ready = 1'b0; c_in = '0;
    step(); step();
    check("rst_valid", coef_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coef_out", coef_out, 0);
    check("rst_poly_idx", poly_idx, 0);
    check("rst_coef_idx", coef_idx, 0);
    check("rst_last", coef_last, 0);
    rst = 1'b0;
    step();

    // all-zero ciphertext, ready held high
    coef_ready = 1'b1; c_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_latency_valid", coef_valid, 1);
    collect(0, -1);
    errs = 0;
    for (int i = 0; i < 768; i++) if (got[i] !== 12'd0) errs++;
    check("t1_zero_coefs", errs, 0);
    check("t1_busy_cycles", busy_cyc, 768);
    step();
    check("t1_done_one_cycle", done, 0);

    // hand-computed boundary vectors
    c2 = '0;
    c2[9:0]       = 10'd1;
    c2[19:10]     = 10'd1023;
    c2[5123:5120] = 4'd1;
    c2[5127:5124] = 4'd8;
    c2[6143:6140] = 4'd15;
    c_in = c2; start = 1'b1;
    step();
    start = 1'b0;
    collect(0, -1);
    check("t2_u0_0", got[0], 3);
    check("t2_u0_1", got[1], 3326);
    check("t2_u0_2", got[2], 0);
    check("t2_v_0", got[512], 208);
    check("t2_v_1", got[513], 1665);
    check("t2_v_255", got[767], 3121);

    // random ciphertext: reference run, model check, then random backpressure
    for (int i = 0; i < 192; i++) crand[i*32 +: 32] = $urandom();
    c_in = crand; start = 1'b1;
    step();
    start = 1'b0;
    collect(0, -1);
    errs = 0;
    for (int j = 0; j < 768; j++) begin
      ref_s[j] = got[j];
      if (j < 512) begin
        if (got[j] !== sw_dec(int'(crand[j*10 +: 10]), 10)) errs++;
      end else begin
        if (got[j] !== sw_dec(int'(crand[5120 + (j - 512)*4 +: 4]), 4)) errs++;
      end
    end
    check("t3_model_errors", errs, 0);
    c_in = crand; start = 1'b1;
    step();
    start = 1'b0;
    collect(1, -1);
    errs = 0;
    for (int j = 0; j < 768; j++) if (got[j] !== ref_s[j]) errs++;
    check("t3_backpressure_errors", errs, 0);

    // start mid-stream ignored; start in the done cycle accepted
    c_in = crand; start = 1'b1;
    step();
    start = 1'b0;
    collect(0, 356);
    errs = 0;
    for (int j = 0; j < 768; j++) if (got[j] !== ref_s[j]) errs++;
    check("t4_midstart_errors", errs, 0);
    c_in = c2; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_valid", coef_valid, 1);
    check("t4_restart_coef", coef_out, 3);
    check("t4_restart_idx", coef_idx, 0);
    collect(0, -1);
    check("t4_restart_u0_1", got[1], 3326);

    // reset mid-stream at u1 coefficient 37
    c_in = c2; start = 1'b1;
    step();
    start = 1'b0; coef_ready = 1'b1;
    cycles = 0;
    while (!(poly_idx == 2'd1 && coef_idx == 8'd37) && cycles < 2000) begin
      step();
      cycles++;
    end
    check("t5_reached_u1_37", {poly_idx, coef_idx}, {2'd1, 8'd37});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_valid", coef_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    c_in = c2; start = 1'b1;
    step();
    start = 1'b0;
    collect(0, -1);
    check("t5_u0_0", got[0], 3);
    check("t5_v_255", got[767], 3121);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
